// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1-to-L2 cache arbiter: FSM state encoding and line type.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int ARB_LINE_W = 256;
  localparam int STARVE_W   = 4;

  typedef logic [ARB_LINE_W-1:0] cache_line_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of requester, memory-side and perf/debug signals around the cache arbiter.
interface cache_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) ();
    import rv32i_types::*;

    // Requests are levels held until the matching one-cycle resp pulse;
    // mem_read/mem_write are levels held until the one-cycle mem_resp.
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    logic [31:0]       perf_i_grants;
    logic [31:0]       perf_d_grants;
    logic [31:0]       perf_conflicts;
    arb_state_t        dbg_state;
    logic [STARVE_W-1:0] dbg_starve_cnt;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr,
               mem_wdata, perf_i_grants, perf_d_grants, perf_conflicts,
               dbg_state, dbg_starve_cnt
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr,
               mem_wdata, perf_i_grants, perf_d_grants, perf_conflicts,
               dbg_state, dbg_starve_cnt
    );

endinterface

// File: rtl/cache_arbiter_starve_counter.sv
// Saturating count of D grants taken while an I request waits; clear wins over inc.
module arb_starve_counter
    import rv32i_types::*;
#(
    parameter int LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc_i,
    input  logic                clr_i,
    output logic                at_limit_o,
    output logic [STARVE_W-1:0] cnt_o
);

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    assign at_limit_o = (cnt_q == STARVE_W'(LIMIT));
    assign cnt_o      = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_limit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// D-priority single-transaction arbiter for the shared L2 line port with bounded I starvation.
// Optional grant/conflict counters are built when CACHE_ARB_PERF_EN is defined.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W       = 256,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    cache_arbiter_if.slave  bus
);

    arb_state_t        state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_resp_q, i_resp_d;
    logic              d_resp_q, d_resp_d;
    logic              grant_i, grant_d;
    logic              i_pend, d_pend;
    logic              at_limit;
    logic [STARVE_W-1:0] starve_cnt;

    assign i_pend = bus.i_read;
    assign d_pend = bus.d_read | bus.d_write;

    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (grant_d & i_pend),
        .clr_i      (grant_i | (grant_d & ~i_pend)),
        .at_limit_o (at_limit),
        .cnt_o      (starve_cnt)
    );

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_resp_d    = 1'b0;
        d_resp_d    = 1'b0;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_pend && !(i_pend && at_limit)) begin
                    grant_d     = 1'b1;
                    state_d     = D_BUSY;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    // read+write together is illegal; the write wins.
                    mem_write_d = bus.d_write;
                    mem_read_d  = ~bus.d_write;
                end else if (i_pend) begin
                    grant_i     = 1'b1;
                    state_d     = I_BUSY;
                    mem_addr_d  = bus.i_addr;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                end
            end
            I_BUSY: begin
                if (bus.mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    i_rdata_d   = bus.mem_rdata;
                    i_resp_d    = 1'b1;
                    state_d     = RESP;
                end
            end
            D_BUSY: begin
                if (bus.mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                    d_resp_d    = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_resp_q    <= i_resp_d;
            d_resp_q    <= d_resp_d;
        end
    end

    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.i_rdata        = i_rdata_q;
    assign bus.d_rdata        = d_rdata_q;
    assign bus.i_resp         = i_resp_q;
    assign bus.d_resp         = d_resp_q;
    assign bus.dbg_state      = state_q;
    assign bus.dbg_starve_cnt = starve_cnt;

`ifdef CACHE_ARB_PERF_EN
    logic [31:0] perf_i_q, perf_d_q, perf_c_q;
    logic        conflict;

    assign conflict = (state_q == IDLE) && i_pend && d_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_i_q <= '0;
            perf_d_q <= '0;
            perf_c_q <= '0;
        end else begin
            perf_i_q <= perf_i_q + {31'd0, grant_i};
            perf_d_q <= perf_d_q + {31'd0, grant_d};
            perf_c_q <= perf_c_q + {31'd0, conflict};
        end
    end

    assign bus.perf_i_grants  = perf_i_q;
    assign bus.perf_d_grants  = perf_d_q;
    assign bus.perf_conflicts = perf_c_q;
`else
    assign bus.perf_i_grants  = '0;
    assign bus.perf_d_grants  = '0;
    assign bus.perf_conflicts = '0;
`endif

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Arbitrates the shared physical-memory (L2) line port between the I-cache and the D-cache miss/writeback paths of the 5-stage RV32I pipeline.
- Sits below both L1 caches. Serves one line transaction at a time.
- D-side has priority because MA_stall freezes the whole pipe. A bounded starvation counter guarantees I-fetch progress.
- All memory-side outputs and requester responses are registered.

Parameters:
- LINE_W, 256, cache line width in bits.
- ADDR_W, 32, byte address width; the arbiter forwards addresses unmodified.
- STARVE_LIMIT, 4, max consecutive D grants while an I request is pending (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- i_read  in  1  I-cache line read request; held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line fill request; held until d_resp
- d_write  in  1  D-cache writeback request; held until d_resp
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory read strobe; level, held until mem_resp
- mem_write  out  1  memory write strobe; level, held until mem_resp
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  LINE_W  memory write line
- mem_rdata  in  LINE_W  memory read line, valid with mem_resp
- mem_resp  in  1  memory completion, one cycle
- perf_i_grants  out  32  I grant count (see Optional Feature)
- perf_d_grants  out  32  D grant count
- perf_conflicts  out  32  cycles both sides requested in IDLE

Behaviour:
- Outputs after reset: all strobes/resp 0, mem_addr/mem_wdata/i_rdata/d_rdata 0, perf_* 0, state IDLE, starve_cnt 0.
- FSM states: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE grant rule:
  - Only D pending (d_read|d_write) -> D_BUSY.
  - Only I pending -> I_BUSY.
  - Both pending: I_BUSY if starve_cnt == STARVE_LIMIT, else D_BUSY.
- On grant:
  - Latch addr and wdata into the memory-side registers; assert mem_read or mem_write from the next cycle.
  - Latency: request in IDLE at cycle t -> strobe visible at t+1.
- d_read and d_write both high is illegal. Treat it as a write; a bench assertion flags it.
- I_BUSY/D_BUSY:
  - Hold mem_* stable. Ignore requester input changes.
  - On mem_resp: drop strobes next cycle; capture mem_rdata into i_rdata or d_rdata; pulse i_resp or d_resp for exactly one cycle (cycle after mem_resp); go to RESP.
- RESP: single dead cycle so the requester can deassert its request; no grant here; then IDLE.
  - Minimum turnaround: 2 cycles after resp before the next strobe.
- starve_cnt:
  - D grant while I pending -> increment, saturating at STARVE_LIMIT.
  - Any I grant, or D grant with I idle -> clear.
- Rdata stays held until the next capture for the same side.
- mem_resp in IDLE or RESP is spurious: ignore it, no state change.
- rst mid-transaction: immediate return to IDLE with strobes low. The memory model is reset in the same cycle; no resp is delivered.

Optional Feature:
- Macro: CACHE_ARB_PERF_EN.
- Defined:
  - perf_i_grants and perf_d_grants increment on each grant.
  - perf_conflicts increments each IDLE cycle with both sides requesting.
  - All three are 32-bit wrapping counters, cleared by rst.
- Undefined: the three outputs are tied to 0 and no counter flops are synthesized.

Decomposition:
- rv32i_types package:
  - arb_state_t enum {IDLE, I_BUSY, D_BUSY, RESP}.
  - Constant ARB_LINE_W = 256.
  - Typedef cache_line_t = logic [255:0].
- One natural sub-module, arb_starve_counter: saturating counter with inc/clr/at_limit.
- FSM and datapath registers stay in cache_arbiter.

Test Plan:
- I-only read: i_read=1, i_addr=0x0000_0040, mem_resp after 5 cycles with rdata=0xA5..A5 -> mem_read high t+1..t+5, i_resp one pulse at t+6, i_rdata=0xA5..A5, d_resp never.
- Simultaneous: i_read and d_read at the same cycle (addrs 0x100/0x200) -> D served first (mem_addr=0x200), then I (mem_addr=0x100) after RESP; i_rdata/d_rdata each carry their own line.
- D writeback: d_write=1, d_addr=0x8000_0020, d_wdata=pattern -> mem_write=1, mem_wdata=pattern held stable until mem_resp; d_resp pulse; mem_read stays 0.
- Starvation: i_read held while D issues back-to-back requests, STARVE_LIMIT=4 -> exactly 4 D grants, then I granted; starve_cnt back to 0.
- Reset mid-op: rst during D_BUSY -> next cycle mem_read=0, state IDLE, no d_resp; a fresh i_read then completes normally.
- With CACHE_ARB_PERF_EN: the simultaneous scenario -> perf_d_grants=1, perf_i_grants=1, perf_conflicts=1. Without the macro, all perf_* read 0.
